sram_bridge_param: RTL
======================

Name: sram_bridge_param

Overview:
- Parametrised bridge between the ARM_cpu memory stage and an external asynchronous SRAM. Narrow-data SRAM is the case on the board.
- Splits one DATA_W CPU access into DATA_W/SRAM_DQ_W sequential SRAM beats, each with a programmable wait-state count.
- Holds ready low so the pipeline freezes until the access completes.
- Successor to the fixed 32-to-16-bit single-wait SRAM path the CPU top uses today.

Parameters:
- DATA_W, 32, CPU data width; must be an integer multiple of SRAM_DQ_W.
- SRAM_DQ_W, 16, SRAM data bus width.
- SRAM_ADDR_W, 18, SRAM address width.
- BASE_ADDR, 1024, CPU byte address mapped to SRAM address 0.
- WAIT_CYCLES, 1, extra cycles per beat, range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request; level, held until ready.
- rd_en  in  1  read request; level, held until ready.
- address  in  32  CPU byte address; DATA_W/8-aligned.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; valid while ready=1 after a read.
- ready  out  1  low = freeze pipeline.
- SRAM_WE_N  out  1  SRAM write enable, active low.
- SRAM_ADDR  out  SRAM_ADDR_W  SRAM halfword (SRAM_DQ_W-wide) address.
- SRAM_DQ  inout  SRAM_DQ_W  bidirectional data; Z when not writing.

Behaviour:
- Constants:
  - BEATS = DATA_W/SRAM_DQ_W.
  - Beat k address = ((address - BASE_ADDR) >> log2(SRAM_DQ_W/8)) + k, truncated to SRAM_ADDR_W.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If wr_en|rd_en is high, latch address, wdata and op, then go to ACCESS with beat=0 and wait=0.
  - If both are high, write wins.
- ACCESS:
  - Each beat lasts WAIT_CYCLES+1 cycles, and the wait counter counts up.
  - On the last cycle of a beat: read samples SRAM_DQ into rdata slice [k*SRAM_DQ_W +: SRAM_DQ_W], so beat 0 is the least significant. Then beat increments.
  - After beat BEATS-1 completes, go to DONE.
- DONE: one cycle, then IDLE.
- ready:
  - ready = 1 in DONE.
  - ready = 1 in IDLE when no request is present.
  - ready = 0 otherwise, including the IDLE cycle in which a request is first seen.
- Latency: request to ready = 1 + BEATS*(WAIT_CYCLES+1) cycles.
- CPU contract: the CPU drops or changes the request in the cycle after ready. A request still high in IDLE is a new access.
- SRAM_WE_N:
  - 0 for every cycle of ACCESS during a write.
  - 1 otherwise.
- SRAM_DQ:
  - Driven with the write beat slice while SRAM_WE_N=0.
  - Z otherwise, including reads, IDLE and DONE.
- SRAM_ADDR:
  - Beat address during ACCESS.
  - Holds its last value elsewhere; 0 after reset.
- rdata: holds until the next read completes; never changes on writes.
- Reset (async, any state):
  - State IDLE, counters 0.
  - SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0, rdata=0.
  - An aborted write may leave a partially written word.
- WAIT_CYCLES=0: one cycle per beat; the wait counter never increments.
- Address below BASE_ADDR wraps modulo 2^SRAM_ADDR_W; no error is flagged.

Optional Feature:
- Macro: SRAM_BRIDGE_READ_BUF_EN.
- With the macro:
  - A one-entry read buffer holds the last completed read address and data plus a valid bit.
  - A read in IDLE whose address matches a valid entry goes directly to DONE with no SRAM cycles and rdata = buffered data. Latency is 1 cycle; ready is low in the IDLE cycle.
  - Any write invalidates the buffer at request latch.
  - Reset clears valid.
- Without the macro: every read performs full SRAM beats.

Decomposition:
- Shared package/include sram_bridge_defs holds:
  - State encodings IDLE/ACCESS/DONE.
  - The BEATS derivation.
  - The log2 function used for the address shift.
- One natural sub-module, sram_beat_seq: the wait/beat counter pair. Inputs are start, BEATS and WAIT_CYCLES; outputs are beat index, beat_last and done.
- The read buffer stays inline under the macro.

Test Plan (defaults unless stated):
- Write 0xDEADBEEF to 1024:
  - SRAM[0]=0xBEEF and SRAM[1]=0xDEAD.
  - SRAM_WE_N low for exactly 4 cycles.
  - ready high on cycle 5 after the request edge.
- Read from 1024 after the above:
  - rdata=0xDEADBEEF with ready on cycle 5.
  - SRAM_DQ is Z throughout from the bridge.
- WAIT_CYCLES=0 and WAIT_CYCLES=3: read at 1028 completes in 3 and 9 cycles respectively; SRAM_ADDR sequence is 2, 3.
- wr_en and rd_en both high at 1032 with wdata 0x12345678: write performed, SRAM[4]=0x5678, rdata unchanged.
- Assert rst mid-write after beat 0: outputs return immediately to SRAM_WE_N=1, Z, ADDR 0, ready=1 with no request. The next read completes normally.
- SRAM_BRIDGE_READ_BUF_EN:
  - Two back-to-back reads of 1024: the second gives ready on cycle 1 with no SRAM_ADDR activity.
  - An intervening write forces the full 5-cycle read.

Source files
------------

// File: rtl/sram_bridge_param_pkg.sv
// Shared definitions for the CPU-to-SRAM bridge: FSM encodings,
// beat-count derivation and the log2 helper used for address shifts.
package sram_bridge_defs;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    function automatic int clog2_i(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int beats_of(input int dw, input int qw);
        return dw / qw;
    endfunction

endpackage

// File: rtl/sram_bridge_param_beat_seq.sv
// Wait/beat counter pair: walks beats 0..beats-1, each lasting
// wait_cycles+1 cycles while en is high; start rewinds both counters.
module sram_beat_seq #(
    parameter int BW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    input  logic [BW:0]   beats,
    input  logic [3:0]    wait_cycles,
    output logic [BW-1:0] beat,
    output logic          beat_last,
    output logic          done
);

    logic [3:0]  wcnt;
    logic [BW:0] last_idx;

    assign last_idx  = beats - {{BW{1'b0}}, 1'b1};
    assign beat_last = en && (wcnt == wait_cycles);
    assign done      = beat_last && ({1'b0, beat} == last_idx);

    // advance the wait counter, rolling into the next beat on its last cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat <= '0;
            wcnt <= '0;
        end else if (start) begin
            beat <= '0;
            wcnt <= '0;
        end else if (en) begin
            if (beat_last) begin
                wcnt <= '0;
                if (!done) beat <= beat + BW'(1);
            end else begin
                wcnt <= wcnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/sram_bridge_param.sv
// CPU memory-stage to async SRAM bridge; splits each access into beats.
// Optional one-entry read buffer enabled by SRAM_BRIDGE_READ_BUF_EN.
module sram_bridge_param
    import sram_bridge_defs::*;
#(
    parameter int DATA_W      = 32,
    parameter int SRAM_DQ_W   = 16,
    parameter int SRAM_ADDR_W = 18,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ready,
    output logic                   SRAM_WE_N,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ
);

    localparam int BEATS = beats_of(DATA_W, SRAM_DQ_W);
    localparam int BW    = (clog2_i(BEATS) < 1) ? 1 : clog2_i(BEATS);
    localparam int SH    = clog2_i(SRAM_DQ_W / 8);

    logic [1:0]             state;
    logic                   op_wr;
    logic [SRAM_ADDR_W-1:0] base_q;
    logic [SRAM_ADDR_W-1:0] addr_hold;
    logic [SRAM_ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      rdata_q;
    logic [31:0]            offset;
    logic [SRAM_DQ_W-1:0]   dq_out;
    logic                   req;
    logic                   in_access;
    logic                   start;
    logic                   hit;
    logic [BW-1:0]          beat;
    logic                   beat_last;
    logic                   seq_done;

    assign req       = wr_en | rd_en;
    assign in_access = (state == ST_ACCESS);
    assign start     = (state == ST_IDLE) && req;
    assign offset    = address - 32'(BASE_ADDR);
    assign beat_addr = base_q + SRAM_ADDR_W'(beat);

    assign ready     = (state == ST_DONE) || ((state == ST_IDLE) && !req);
    assign rdata     = rdata_q;
    assign SRAM_WE_N = !(in_access && op_wr);
    assign SRAM_ADDR = in_access ? beat_addr : addr_hold;
    assign SRAM_DQ   = SRAM_WE_N ? {SRAM_DQ_W{1'bz}} : dq_out;

    sram_beat_seq #(
        .BW(BW)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .en         (in_access),
        .beats      ((BW+1)'(BEATS)),
        .wait_cycles(4'(WAIT_CYCLES)),
        .beat       (beat),
        .beat_last  (beat_last),
        .done       (seq_done)
    );

`ifdef SRAM_BRIDGE_READ_BUF_EN
    logic              buf_valid;
    logic [31:0]       buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic [31:0]       addr_q;

    assign hit = rd_en && !wr_en && buf_valid && (buf_addr == address);

    // remember the last completed read; any write drops the entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            addr_q    <= '0;
        end else begin
            if (start) begin
                addr_q <= address;
                if (wr_en) buf_valid <= 1'b0;
            end
            if ((state == ST_DONE) && !op_wr) begin
                buf_valid <= 1'b1;
                buf_addr  <= addr_q;
                buf_data  <= rdata_q;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    // write-beat slice for the current beat
    always_comb begin
        dq_out = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (int'(beat) == k) dq_out = wdata_q[k*SRAM_DQ_W +: SRAM_DQ_W];
        end
    end

    // main control FSM; write wins when both requests are high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_wr   <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        op_wr   <= wr_en;
                        base_q  <= SRAM_ADDR_W'(offset >> SH);
                        wdata_q <= wdata;
                        state   <= hit ? ST_DONE : ST_ACCESS;
                    end
                end
                ST_ACCESS: if (seq_done) state <= ST_DONE;
                ST_DONE:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // SRAM_ADDR keeps the last beat address outside ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_hold <= '0;
        else if (in_access) addr_hold <= beat_addr;
    end

    // assemble read data, least significant beat first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (in_access && !op_wr && beat_last) begin
            for (int k = 0; k < BEATS; k++) begin
                if (int'(beat) == k) rdata_q[k*SRAM_DQ_W +: SRAM_DQ_W] <= SRAM_DQ;
            end
        end
`ifdef SRAM_BRIDGE_READ_BUF_EN
        else if ((state == ST_IDLE) && hit) begin
            rdata_q <= buf_data;
        end
`endif
    end

endmodule
